// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-requester RAM port arbiter.
// The tag travels alongside each issued read so its data returns to the right requester.
package ram_arb_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_ADDR_WIDTH    = 3;
    localparam int DEF_READ_LATENCY  = 4;
    localparam int DEF_WRITE_LATENCY = 5;
    localparam int DEF_NUM_REQ       = 2;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/ram_arb_delay_line.sv
// Fixed-depth shift register with every stage exposed, cleared by reset.
// Serves as both the read tag pipeline and the in-flight write scoreboard.
module ram_arb_delay_line #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [WIDTH-1:0]       i_data,
    output logic [DEPTH*WIDTH-1:0] o_taps
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Stage i occupies slice i of the tap bus.
    for (genvar g = 0; g < DEPTH; g++) begin : g_taps
        assign o_taps[g*WIDTH +: WIDTH] = stage_q[g];
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one pipelined RAM port between two requesters.
// Reads to an address with a write still committing are held back; the other requester proceeds.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int READ_LATENCY  = DEF_READ_LATENCY,
    parameter int WRITE_LATENCY = DEF_WRITE_LATENCY,
    parameter int NUM_REQ       = DEF_NUM_REQ
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ-1:0]            i_req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_din,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    output logic                          o_mem_en,
    output logic                          o_mem_we,
    output logic [ADDR_WIDTH-1:0]         o_mem_addr,
    output logic [DATA_WIDTH-1:0]         o_mem_din,
    input  logic [DATA_WIDTH-1:0]         i_mem_dout,
    output logic [3:0]                    o_rd_inflight
);

    localparam int TAG_W = $bits(tag_t);
    localparam int SB_W  = ADDR_WIDTH + 1;

    logic [NUM_REQ-1:0]    hit, elig, grant;
    req_id_t               ptr_q, gid;
    logic                  hs, sel_we, rd_hs;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_din;

    logic [SB_W-1:0]                      sb_in;
    logic [WRITE_LATENCY*SB_W-1:0]        sb_taps;
    tag_t                                 tag_in, tag_out;
    logic [(READ_LATENCY+1)*TAG_W-1:0]    tag_taps;
    logic                                 unused_tag_taps;

    logic                  mem_en_q, mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_din_q;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [3:0]            inflight_q, inflight_d;

    // Scoreboard entry layout: {valid, addr}.
    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int e = 0; e < WRITE_LATENCY; e++) begin
                if (sb_taps[e*SB_W + ADDR_WIDTH] &&
                    sb_taps[e*SB_W +: ADDR_WIDTH] == i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    hit[k] = 1'b1;
                end
            end
        end
    end

    assign elig = i_req_valid & (i_req_we | ~hit);

    always_comb begin
        grant = '0;
        if (!i_rst) begin
            if (elig[ptr_q]) begin
                grant[ptr_q] = 1'b1;
            end else if (elig[~ptr_q]) begin
                grant[~ptr_q] = 1'b1;
            end
        end
    end

    assign hs       = |grant;
    assign gid      = grant[1];
    assign sel_we   = i_req_we[gid];
    assign sel_addr = i_req_addr[int'(gid)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_din  = i_req_din[int'(gid)*DATA_WIDTH +: DATA_WIDTH];
    assign rd_hs    = hs & ~sel_we;

    assign sb_in   = {hs & sel_we, sel_addr};
    assign tag_in  = '{valid: rd_hs, id: gid};
    assign tag_out = tag_taps[READ_LATENCY*TAG_W +: TAG_W];
    assign unused_tag_taps = ^tag_taps[READ_LATENCY*TAG_W-1:0];

    ram_arb_delay_line #(.DEPTH(WRITE_LATENCY), .WIDTH(SB_W)) u_wr_scoreboard (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_data (sb_in),
        .o_taps (sb_taps)
    );

    // One extra stage so the tag lines up with RAM data READ_LATENCY after the port cycle.
    ram_arb_delay_line #(.DEPTH(READ_LATENCY + 1), .WIDTH(TAG_W)) u_tag_pipe (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_data (tag_in),
        .o_taps (tag_taps)
    );

    always_comb begin
        inflight_d = inflight_q;
        if (rd_hs && !(|rsp_valid_q)) begin
            inflight_d = inflight_q + 4'd1;
        end else if (!rd_hs && (|rsp_valid_q)) begin
            inflight_d = inflight_q - 4'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            inflight_q  <= '0;
        end else begin
            mem_en_q   <= hs;
            mem_we_q   <= hs & sel_we;
            inflight_q <= inflight_d;
            if (hs) begin
                ptr_q      <= ~gid;
                mem_addr_q <= sel_addr;
                mem_din_q  <= sel_din;
            end
            rsp_valid_q <= '0;
            if (tag_out.valid) begin
                rsp_valid_q[tag_out.id] <= 1'b1;
                rsp_data_q              <= i_mem_dout;
            end
        end
    end

    assign o_req_ready   = grant;
    assign o_mem_en      = mem_en_q;
    assign o_mem_we      = mem_we_q;
    assign o_mem_addr    = mem_addr_q;
    assign o_mem_din     = mem_din_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_data    = rsp_data_q;
    assign o_rd_inflight = inflight_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small behavioural RAM on the memory port.
// Monitors log responses and port commands; each test task checks its own expectations.
module tb_ram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int RL = 4;
    localparam int WL = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    i_req_valid, i_req_we, o_req_ready, o_rsp_valid;
    logic [2*AW-1:0] i_req_addr;
    logic [2*DW-1:0] i_req_din;
    logic [DW-1:0] o_rsp_data, o_mem_din, i_mem_dout;
    logic          o_mem_en, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [3:0]    o_rd_inflight;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_port_arbiter dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_we      (i_req_we),
        .i_req_addr    (i_req_addr),
        .i_req_din     (i_req_din),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_data    (o_rsp_data),
        .o_mem_en      (o_mem_en),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_din     (o_mem_din),
        .i_mem_dout    (i_mem_dout),
        .o_rd_inflight (o_rd_inflight)
    );

    // Behavioural RAM: data for a port read in cycle t appears in cycle t+RL.
    logic [DW-1:0] ram [8];
    logic [DW-1:0] rd_pipe [RL];
    always @(posedge clk) begin
        if (o_mem_en && o_mem_we) ram[o_mem_addr] <= o_mem_din;
        rd_pipe[0] <= ram[o_mem_addr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign i_mem_dout = rd_pipe[RL-1];

    int         rsp_cyc_q[$];
    logic [7:0] rsp_dat_q[$];
    logic [1:0] rsp_vld_q[$];
    int         mem_cyc_q[$];
    logic [11:0] mem_cmd_q[$];

    always @(negedge clk) begin
        if (o_rsp_valid != 2'b00) begin
            rsp_cyc_q.push_back(cyc);
            rsp_dat_q.push_back(o_rsp_data);
            rsp_vld_q.push_back(o_rsp_valid);
        end
        if (o_mem_en) begin
            mem_cyc_q.push_back(cyc);
            mem_cmd_q.push_back({o_mem_we, o_mem_addr, o_mem_din});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds a command until accepted; returns the handshake cycle, -1 on timeout.
    task automatic do_cmd(input int k, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] din, output int hs);
        hs = -1;
        i_req_valid[k] = 1'b1;
        i_req_we[k] = we;
        i_req_addr[k*AW +: AW] = addr;
        i_req_din[k*DW +: DW] = din;
        for (int n = 0; n < 20 && hs < 0; n++) begin
            @(negedge clk);
            if (o_req_ready[k]) hs = cyc;
            @(posedge clk);
            #1;
        end
        i_req_valid[k] = 1'b0;
        if (hs < 0) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: requester %0d got no ready, expected one within 20 cycles", k);
        end
    endtask

    task automatic test_reset();
        int c0, hs;
        i_req_valid = 2'b01;
        i_req_we = 2'b11;
        i_req_addr = {3'd7, 3'd7};
        i_req_din = 16'h7777;
        rst = 1'b1;
        tick(2);
        @(negedge clk);
        checks++;
        if (o_req_ready !== 2'b00 || o_mem_en !== 1'b0 || o_mem_we !== 1'b0 ||
            o_rsp_valid !== 2'b00 || o_rd_inflight !== 4'd0 || o_mem_addr !== 3'd0 ||
            o_mem_din !== 8'd0 || o_rsp_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b en=%b we=%b rsp=%b infl=%0d addr=%0d din=%h data=%h, expected all 0",
                     o_req_ready, o_mem_en, o_mem_we, o_rsp_valid, o_rd_inflight, o_mem_addr, o_mem_din, o_rsp_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        c0 = cyc;
        do_cmd(0, 1'b1, 3'd7, 8'h77, hs);
        checks++;
        if (hs !== c0) begin
            errors++;
            $display("FAIL first_handshake: got cycle %0d, expected %0d", hs, c0);
        end
        tick(8);
    endtask

    task automatic test_write_read();
        int hw[4], hr[4];
        int rb, mb;
        rb = rsp_cyc_q.size();
        mb = mem_cyc_q.size();
        for (int i = 0; i < 4; i++) do_cmd(0, 1'b1, 3'(i), 8'hA0 + 8'(i), hw[i]);
        for (int i = 0; i < 4; i++) do_cmd(0, 1'b0, 3'(i), 8'h00, hr[i]);
        @(negedge clk);
        checks++;
        if (o_rd_inflight !== 4'd4) begin
            errors++;
            $display("FAIL inflight_4: got %0d, expected 4", o_rd_inflight);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (hw[i] !== hw[0] + i || hr[i] !== hr[0] + i) begin
                errors++;
                $display("FAIL back_to_back_%0d: got w=%0d r=%0d, expected w=%0d r=%0d",
                         i, hw[i], hr[i], hw[0] + i, hr[0] + i);
            end
        end
        checks++;
        if (hr[0] !== hw[0] + 6) begin
            errors++;
            $display("FAIL raw_release_addr0: got read at %0d, expected %0d", hr[0], hw[0] + 6);
        end
        tick(10);
        checks++;
        if (mem_cyc_q.size() - mb !== 8) begin
            errors++;
            $display("FAIL mem_cmd_count: got %0d, expected 8", mem_cyc_q.size() - mb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (mem_cyc_q[mb+i] !== hw[i] + 1 || mem_cmd_q[mb+i] !== {1'b1, 3'(i), 8'hA0 + 8'(i)}) begin
                    errors++;
                    $display("FAIL mem_write_%0d: got cyc=%0d cmd=%h, expected cyc=%0d cmd=%h", i,
                             mem_cyc_q[mb+i], mem_cmd_q[mb+i], hw[i] + 1, {1'b1, 3'(i), 8'hA0 + 8'(i)});
                end
                checks++;
                if (mem_cyc_q[mb+4+i] !== hr[i] + 1 || mem_cmd_q[mb+4+i][11:8] !== {1'b0, 3'(i)}) begin
                    errors++;
                    $display("FAIL mem_read_%0d: got cyc=%0d we/addr=%h, expected cyc=%0d we/addr=%h", i,
                             mem_cyc_q[mb+4+i], mem_cmd_q[mb+4+i][11:8], hr[i] + 1, {1'b0, 3'(i)});
                end
            end
        end
        checks++;
        if (rsp_cyc_q.size() - rb !== 4) begin
            errors++;
            $display("FAIL wr_rd_rsp_count: got %0d, expected 4", rsp_cyc_q.size() - rb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rsp_cyc_q[rb+i] !== hr[i] + 6 || rsp_dat_q[rb+i] !== 8'hA0 + 8'(i) || rsp_vld_q[rb+i] !== 2'b01) begin
                    errors++;
                    $display("FAIL wr_rd_rsp_%0d: got cyc=%0d data=%h vld=%b, expected cyc=%0d data=%h vld=01", i,
                             rsp_cyc_q[rb+i], rsp_dat_q[rb+i], rsp_vld_q[rb+i], hr[i] + 6, 8'hA0 + 8'(i));
                end
            end
        end
        checks++;
        if (o_rd_inflight !== 4'd0) begin
            errors++;
            $display("FAIL inflight_drained: got %0d, expected 0", o_rd_inflight);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] got [4];
        logic [1:0] exp_g [4];
        logic [7:0] exp_d [4];
        int rb;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_d = '{8'hA0, 8'hA1, 8'hA0, 8'hA1};
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        rb = rsp_cyc_q.size();
        i_req_we = 2'b00;
        i_req_addr = {3'd1, 3'd0};
        i_req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got[i] = o_req_ready;
            @(posedge clk);
            #1;
        end
        i_req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp_g[i]) begin
                errors++;
                $display("FAIL rr_grant_%0d: got %b, expected %b", i, got[i], exp_g[i]);
            end
        end
        tick(10);
        checks++;
        if (rsp_cyc_q.size() - rb !== 4) begin
            errors++;
            $display("FAIL rr_rsp_count: got %0d, expected 4", rsp_cyc_q.size() - rb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rsp_vld_q[rb+i] !== exp_g[i] || rsp_dat_q[rb+i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL rr_rsp_%0d: got vld=%b data=%h, expected vld=%b data=%h", i,
                             rsp_vld_q[rb+i], rsp_dat_q[rb+i], exp_g[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_raw_block();
        int hw, hr, rb;
        rb = rsp_cyc_q.size();
        do_cmd(1, 1'b1, 3'd5, 8'hB5, hw);
        do_cmd(1, 1'b0, 3'd5, 8'h00, hr);
        checks++;
        if (hr !== hw + 6) begin
            errors++;
            $display("FAIL raw_block: got read handshake %0d, expected %0d", hr, hw + 6);
        end
        tick(10);
        checks++;
        if (rsp_cyc_q.size() - rb !== 1 || rsp_cyc_q[rb] !== hr + 6 ||
            rsp_dat_q[rb] !== 8'hB5 || rsp_vld_q[rb] !== 2'b10) begin
            errors++;
            $display("FAIL raw_rsp: got n=%0d, expected 1 rsp at %0d data B5 vld 10", rsp_cyc_q.size() - rb, hr + 6);
        end
    endtask

    task automatic test_no_stall();
        int h6, hw, h0, c1, rb;
        logic [1:0] got;
        do_cmd(0, 1'b1, 3'd6, 8'h66, h6);
        tick(6);
        rb = rsp_cyc_q.size();
        do_cmd(1, 1'b1, 3'd5, 8'h5C, hw);
        i_req_we = 2'b00;
        i_req_addr = {3'd6, 3'd5};
        i_req_valid = 2'b11;
        @(negedge clk);
        got = o_req_ready;
        c1 = cyc;
        @(posedge clk);
        #1;
        i_req_valid[1] = 1'b0;
        checks++;
        if (got !== 2'b10) begin
            errors++;
            $display("FAIL no_stall_grant: got %b, expected 10", got);
        end
        do_cmd(0, 1'b0, 3'd5, 8'h00, h0);
        checks++;
        if (h0 !== hw + 6) begin
            errors++;
            $display("FAIL blocked_release: got %0d, expected %0d", h0, hw + 6);
        end
        tick(10);
        checks++;
        if (rsp_cyc_q.size() - rb !== 2) begin
            errors++;
            $display("FAIL no_stall_rsp_count: got %0d, expected 2", rsp_cyc_q.size() - rb);
        end else begin
            checks++;
            if (rsp_cyc_q[rb] !== c1 + 6 || rsp_dat_q[rb] !== 8'h66 || rsp_vld_q[rb] !== 2'b10 ||
                rsp_cyc_q[rb+1] !== h0 + 6 || rsp_dat_q[rb+1] !== 8'h5C || rsp_vld_q[rb+1] !== 2'b01) begin
                errors++;
                $display("FAIL no_stall_rsp: got %0d/%h/%b then %0d/%h/%b, expected %0d/66/10 then %0d/5c/01",
                         rsp_cyc_q[rb], rsp_dat_q[rb], rsp_vld_q[rb], rsp_cyc_q[rb+1], rsp_dat_q[rb+1],
                         rsp_vld_q[rb+1], c1 + 6, h0 + 6);
            end
        end
    endtask

    task automatic test_reset_inflight();
        int h, rb;
        for (int i = 0; i < 3; i++) do_cmd(0, 1'b0, 3'(i), 8'h00, h);
        @(negedge clk);
        checks++;
        if (o_rd_inflight !== 4'd3) begin
            errors++;
            $display("FAIL inflight_3: got %0d, expected 3", o_rd_inflight);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        rb = rsp_cyc_q.size();
        tick(1);
        rst = 1'b0;
        tick(12);
        checks++;
        if (rsp_cyc_q.size() !== rb || o_rd_inflight !== 4'd0) begin
            errors++;
            $display("FAIL reset_discard: got %0d rsp, inflight %0d, expected 0 and 0",
                     rsp_cyc_q.size() - rb, o_rd_inflight);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_req_valid = 2'b00;
        i_req_we = 2'b00;
        i_req_addr = '0;
        i_req_din = '0;
        #1;
        test_reset();
        test_write_read();
        test_round_robin();
        test_raw_block();
        test_no_stall();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
